freelist: RTL and testbench

- 2-wide circular free list of physical register tags, R10K style.
- Supplies new destination tags to the dispatch stage; freeReg_o drives the ROB's freeReg_i and the map table.
- Reclaims T_old tags that the ROB hands back at retire (ROB T_old_o / retire_en_o).
- Restores itself in one cycle on branch recovery, in step with the ROB.

---
 rtl/freelist_pkg.sv | 23 ++
 rtl/freelist.sv | 135 +++++++++++++
 tb/tb_freelist.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/freelist_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freelist_pkg
// Description : Shared sizing constants and status encoding for the physical
//               register free list.
// Revision    : 1.0 - initial release
// ============================================================================
package freelist_pkg;

  localparam int PREG_NUMBER    = 64;
  localparam int ARCHREG_NUMBER = 32;
  localparam int FL_SIZE        = PREG_NUMBER - ARCHREG_NUMBER;
  localparam int PREG_W         = $clog2(PREG_NUMBER);
  localparam int PTR_W          = $clog2(FL_SIZE);

  typedef enum logic [1:0] {
    FL_EMPTY     = 2'd0,
    FL_ONE_LEFT  = 2'd1,
    FL_MORE_LEFT = 2'd2
  } FL_STATUS;

endpackage
`default_nettype wire

// File: rtl/freelist.sv
`default_nettype none
// ============================================================================
// Module      : freelist
// Description : 2-wide circular free list of physical register tags. Grants
//               up to two tags per cycle from head, reclaims retired T_old
//               tags at tail, and snaps back to full on branch recovery.
// Revision    : 1.0 - initial release
// ============================================================================
module freelist
  import freelist_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             dispatch_en_i,
  input  logic [1:0]             retire_en_i,
  input  logic [1:0][PREG_W-1:0] T_old_i,
  input  logic                   branch_recover_i,
  output logic [1:0][PREG_W-1:0] freeReg_o,
  output FL_STATUS               FL_status_o,
  output logic [PTR_W:0]         free_count_o
`ifdef DEBUG
  ,
  output logic [PTR_W-1:0]       head_debug,
  output logic [PTR_W-1:0]       tail_debug
`endif
);

  localparam logic [PTR_W:0] c_FL_SIZE_CNT = (PTR_W+1)'(FL_SIZE);

  logic [PREG_W-1:0] entries_q [FL_SIZE];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;

  logic [1:0]        w_req;
  logic [1:0]        w_ret;
  logic [1:0]        w_pops;
  logic [1:0]        w_pushes;
  logic [PTR_W:0]    w_space;
  logic [PTR_W-1:0]  w_head_p1;
  logic [PTR_W-1:0]  w_tail_p1;
  logic [PREG_W-1:0] w_wr0_data;
  logic              w_wr0_en;
  logic              w_wr1_en;

  // Demand and supply this cycle, clipped so head never passes tail and
  // tail never overruns head.
  always_comb begin
    w_req    = {1'b0, dispatch_en_i[0]} + {1'b0, dispatch_en_i[1]};
    w_ret    = {1'b0, retire_en_i[0]} + {1'b0, retire_en_i[1]};
    w_space  = c_FL_SIZE_CNT - count_q;
    w_pops   = ((PTR_W+1)'(w_req) > count_q) ? count_q[1:0] : w_req;
    w_pushes = ((PTR_W+1)'(w_ret) > w_space) ? w_space[1:0] : w_ret;
  end

  // Retired tags are compacted: the first enabled one lands at tail.
  assign w_tail_p1  = tail_q + PTR_W'(1);
  assign w_wr0_en   = (w_pushes != 2'd0);
  assign w_wr1_en   = (w_pushes == 2'd2);
  assign w_wr0_data = retire_en_i[0] ? T_old_i[0] : T_old_i[1];

  // Pointer and occupancy update; recovery re-frees every in-flight tag
  // after this cycle's retire pushes have landed.
  always_comb begin
    tail_d  = tail_q + PTR_W'(w_pushes);
    head_d  = head_q + PTR_W'(w_pops);
    count_d = count_q - (PTR_W+1)'(w_pops) + (PTR_W+1)'(w_pushes);
    if (branch_recover_i) begin
      head_d  = tail_d;
      count_d = c_FL_SIZE_CNT;
    end
  end

  // Grants are read straight off head; a lone slot-1 request takes head.
  assign w_head_p1    = head_q + PTR_W'(1);
  assign freeReg_o[0] = entries_q[head_q];
  assign freeReg_o[1] = dispatch_en_i[0] ? entries_q[w_head_p1] : entries_q[head_q];
  assign free_count_o = count_q;

  // Occupancy summary consumed by dispatch as a stall condition.
  always_comb begin
    FL_status_o = FL_MORE_LEFT;
    if (count_q == '0) begin
      FL_status_o = FL_EMPTY;
    end else if (count_q == (PTR_W+1)'(1)) begin
      FL_status_o = FL_ONE_LEFT;
    end
  end

  // Head, tail and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= c_FL_SIZE_CNT;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Tag storage; reset loads the tags not mapped to architectural registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_SIZE; i++) begin
        entries_q[i] <= PREG_W'(ARCHREG_NUMBER + i);
      end
    end else begin
      if (w_wr0_en) begin
        entries_q[tail_q] <= w_wr0_data;
      end
      if (w_wr1_en) begin
        entries_q[w_tail_p1] <= T_old_i[1];
      end
    end
  end

`ifdef DEBUG
  assign head_debug = head_q;
  assign tail_debug = tail_q;

  // Flag dispatch requests dropped for lack of tags and retire overflow.
  always_ff @(posedge clk) begin
    if (reset && !branch_recover_i) begin
      assert (w_pops == w_req);
    end
    if (reset) begin
      assert (w_pushes == w_ret);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_freelist.sv
`default_nettype none
// ============================================================================
// Module      : tb_freelist
// Description : Self-checking bench for freelist. A queue-based model of the
//               free tags drives a scoreboard checked by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freelist;
  import freelist_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [1:0]             dispatch_en_i;
  logic [1:0]             retire_en_i;
  logic [1:0][PREG_W-1:0] T_old_i;
  logic                   branch_recover_i;
  logic [1:0][PREG_W-1:0] freeReg_o;
  FL_STATUS               FL_status_o;
  logic [PTR_W:0]         free_count_o;

  freelist u_dut (
    .clk              (clk),
    .reset            (reset),
    .dispatch_en_i    (dispatch_en_i),
    .retire_en_i      (retire_en_i),
    .T_old_i          (T_old_i),
    .branch_recover_i (branch_recover_i),
    .freeReg_o        (freeReg_o),
    .FL_status_o      (FL_status_o),
    .free_count_o     (free_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int st;
    bit v0;
    int t0;
    bit v1;
    int t1;
    bit g0;
    bit g1;
  } exp_t;

  exp_t exp_q[$];
  // fl: free tags in grant order. gone: granted tags still occupying slots,
  // oldest first (the next retire overwrites the oldest one).
  int   fl[$];
  int   gone[$];
  int   seen[$];
  bit   collect = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic int status_of(input int n);
    if (n == 0) return 0;
    if (n == 1) return 1;
    return 2;
  endfunction

  function automatic void model_reset();
    fl.delete();
    gone.delete();
    for (int i = 0; i < FL_SIZE; i++) fl.push_back(ARCHREG_NUMBER + i);
  endfunction

  function automatic void model_step(input logic [1:0] d, input logic [1:0] r,
                                     input int t1, input int t0, input bit rec);
    int req;
    int pops;
    int space;
    int tags[$];
    req   = int'(d[0]) + int'(d[1]);
    pops  = rec ? 0 : ((req < fl.size()) ? req : fl.size());
    space = FL_SIZE - fl.size();
    if (r[0]) tags.push_back(t0);
    if (r[1]) tags.push_back(t1);
    while (tags.size() > space) void'(tags.pop_back());
    foreach (tags[k]) begin
      void'(gone.pop_front());
      fl.push_back(tags[k]);
    end
    for (int k = 0; k < pops; k++) gone.push_back(fl.pop_front());
    if (rec) begin
      for (int k = gone.size() - 1; k >= 0; k--) fl.push_front(gone[k]);
      gone.delete();
    end
  endfunction

  task automatic drive(input logic [1:0] d, input logic [1:0] r,
                       input int t1, input int t0, input bit rec);
    exp_t e;
    int   n;
    int   idx1;
    int   req;
    int   ng;
    n    = fl.size();
    idx1 = d[0] ? 1 : 0;
    req  = int'(d[0]) + int'(d[1]);
    ng   = rec ? 0 : ((req < n) ? req : n);
    dispatch_en_i    = d;
    retire_en_i      = r;
    T_old_i[1]       = PREG_W'(t1);
    T_old_i[0]       = PREG_W'(t0);
    branch_recover_i = rec;
    e.cnt = n;
    e.st  = status_of(n);
    e.v0  = (n >= 1);
    e.t0  = 0;
    if (e.v0) e.t0 = fl[0];
    e.v1  = d[1] && (n > idx1);
    e.t1  = 0;
    if (e.v1) e.t1 = fl[idx1];
    e.g0  = (d != 2'b10) && (ng >= 1);
    e.g1  = (d == 2'b10) ? (ng >= 1) : (ng == 2);
    exp_q.push_back(e);
    @(posedge clk);
    model_step(d, r, t1, t0, rec);
    #1;
  endtask

  task automatic do_reset();
    reset            = 1'b0;
    dispatch_en_i    = '0;
    retire_en_i      = '0;
    T_old_i          = '0;
    branch_recover_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Monitor: compare the DUT against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("free_count", int'(free_count_o), e.cnt);
      chk("status", int'(FL_status_o), e.st);
      if (e.v0) chk("freeReg0", int'(freeReg_o[0]), e.t0);
      if (e.v1) chk("freeReg1", int'(freeReg_o[1]), e.t1);
      if (collect) begin
        if (e.g0) seen.push_back(int'(freeReg_o[0]));
        if (e.g1) seen.push_back(int'(freeReg_o[1]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, required completion", $time);
    $fatal(1);
  end

  initial begin
    bit used [PREG_NUMBER];
    int dups;

    // Reset state
    reset            = 1'b0;
    dispatch_en_i    = '0;
    retire_en_i      = '0;
    T_old_i          = '0;
    branch_recover_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", int'(free_count_o), FL_SIZE);
    chk("reset_status", int'(FL_status_o), 2);
    chk("reset_tag0", int'(freeReg_o[0]), ARCHREG_NUMBER);
    reset = 1'b1;
    drive(2'b00, 2'b00, 0, 0, 1'b0);

    // Drain all tags two at a time, then an extra request at empty
    repeat (16) drive(2'b11, 2'b00, 0, 0, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0);

    // Retire into an empty list; no same-cycle bypass to dispatch
    drive(2'b11, 2'b11, 5, 4, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0);

    // One left with a two-wide request, then a lone slot-1 request
    drive(2'b00, 2'b01, 0, 7, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    drive(2'b00, 2'b11, 9, 8, 1'b0);
    drive(2'b10, 2'b00, 0, 0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0);

    // Branch recovery with a retire in the same cycle
    do_reset();
    repeat (5) drive(2'b11, 2'b00, 0, 0, 1'b0);
    drive(2'b00, 2'b11, 2, 1, 1'b0);
    drive(2'b00, 2'b11, 4, 3, 1'b0);
    drive(2'b11, 2'b01, 0, 0, 1'b1);
    seen.delete();
    collect = 1'b1;
    repeat (16) drive(2'b11, 2'b00, 0, 0, 1'b0);
    collect = 1'b0;
    chk("recover_ngrants", seen.size(), FL_SIZE);
    dups = 0;
    foreach (seen[k]) begin
      if (used[seen[k]]) dups++;
      used[seen[k]] = 1'b1;
    end
    chk("recover_dups", dups, 0);

    // Randomised traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, PREG_NUMBER - 1)),
            int'($urandom_range(0, PREG_NUMBER - 1)),
            ($urandom_range(0, 31) == 0));
    end

    // Asynchronous reset between clock edges during a dispatch burst
    do_reset();
    repeat (3) drive(2'b11, 2'b00, 0, 0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("async_count", int'(free_count_o), FL_SIZE);
    chk("async_status", int'(FL_status_o), 2);
    chk("async_tag0", int'(freeReg_o[0]), ARCHREG_NUMBER);
    chk("async_tag1", int'(freeReg_o[1]), ARCHREG_NUMBER + 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    drive(2'b11, 2'b00, 0, 0, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
